pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Merges stall requests from the IF/ID/EX/MEM stages into the 6-bit pause vector that every pipeline register consumes.
- Raises a one-cycle clear on exception/ERET commit and supplies the redirect PC.
- Holds that redirect until the fetch stage can accept it, and counts stall cycles for performance monitoring.

Parameters:
- EXC_ENTRY, 32'hBFC00380, general exception vector (BEV=1).
- TLB_REFILL_ENTRY, 32'hBFC00200, TLB refill vector (BEV=1).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  icache miss in progress.
- stall_id  in  1  load-use / operand hazard.
- stall_ex  in  1  multicycle mul/div busy.
- stall_mem  in  1  dcache/uncached access in progress.
- exc_valid  in  1  MEM stage commits an exception or ERET this cycle.
- exc_code  in  5  ExcCode; 5'h1F = ERET (package constant).
- exc_tlb_refill  in  1  exception is a TLB refill (EXL was 0).
- cp0_epc  in  32  current EPC value.
- pause  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB.
- clear  out  1  flush all pipeline registers this cycle.
- redirect_valid  out  1  PC must load redirect_pc.
- redirect_pc  out  32  target PC.
- stall_cycles  out  CNT_W  number of cycles with any pause bit set.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, redirect_pc=0, stall_cycles=0.
  - While rst=1: pause=0, clear=0, redirect_valid=0.
- Pause priority is highest stage first, so the deepest requester wins:
  - stall_mem -> 6'b011111
  - else stall_ex -> 6'b001111
  - else stall_id -> 6'b000111
  - else stall_if -> 6'b000011
  - else 6'b000000
- pause is combinational from the requests, zero latency. A register with pause[k]=1 and pause[k+1]=0 inserts a bubble.
- exc_valid=1 in IDLE:
  - clear=1 combinationally in the same cycle; pause is forced to 0 that cycle (flush overrides stall).
  - Next redirect_pc:
    - cp0_epc if exc_code==ERET;
    - else TLB_REFILL_ENTRY if exc_tlb_refill;
    - else EXC_ENTRY.
  - redirect_pc is latched at the posedge.
  - If stall_if=0 that cycle: state -> REDIRECT, redirect_valid=1 for exactly the next cycle, then back to IDLE.
  - If stall_if=1: state -> WAIT_IF, because the icache cannot abort an in-flight line fill.
- WAIT_IF:
  - redirect_valid=0; pause[0]=pause[1]=1 is forced so no stale instruction enters ID; clear=0.
  - Stays in WAIT_IF while stall_if=1.
  - On the first cycle with stall_if=0, goes to REDIRECT.
- REDIRECT:
  - redirect_valid=1 for one cycle; the PC register loads redirect_pc.
  - Asserts clear again to discard the instruction fetched during the wait.
  - Returns to IDLE.
- exc_valid while not IDLE:
  - Cannot occur architecturally; the pipeline is empty.
  - Ignored; the bench asserts it never happens.
- Simultaneous stall_mem=1 and exc_valid=1: the exception wins. The stalling instruction is flushed and the dcache request is abandoned by its own controller on clear.
- stall_cycles:
  - Increments by 1 every cycle pause!=0, excluding reset cycles.
  - Wraps modulo 2^CNT_W.
  - Cleared only by rst.
- Reset mid-WAIT_IF: returns to IDLE immediately; the pending redirect is dropped.

Decomposition:
- Shared package:
  - pause-vector constants PAUSE_NONE/IF/ID/EX/MEM;
  - ERET code 5'h1F;
  - vector addresses.
- One sub-module, pause_encoder (pure priority encoder, 4 requests -> 6-bit pause).
- FSM, redirect latch and counter stay in pipeline_ctrl.

Test Plan:
- Reset held 2 cycles with all stalls=1 -> pause=0, clear=0, redirect_valid=0, stall_cycles=0 throughout.
- stall_ex=1 for 34 cycles, stall_id=1 concurrently -> pause=6'b001111 each cycle, stall_cycles=34 afterwards.
- exc_valid=1, exc_code=5'h04, stall_if=0 -> clear=1 same cycle, pause=0; next cycle redirect_valid=1, redirect_pc=32'hBFC00380; then IDLE.
- exc_valid with exc_code=ERET, cp0_epc=32'h8000_1234, stall_if=1 for 5 more cycles:
  - pause=6'b000011 during the wait;
  - redirect_valid=1 with pc 32'h80001234 on the cycle after stall_if drops;
  - clear=1 on that same cycle.
- exc_valid=1, exc_tlb_refill=1, stall_mem=1 -> clear=1, pause=0; redirect_pc=32'hBFC00200.
- Enter WAIT_IF, assert rst for 1 cycle -> no redirect_valid pulse ever; state IDLE; stall_cycles=0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int unsigned PAUSE_W = 6;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned EXC_W   = 5;

    localparam logic [PAUSE_W-1:0] PAUSE_NONE = 6'b000000;
    localparam logic [PAUSE_W-1:0] PAUSE_IF   = 6'b000011;
    localparam logic [PAUSE_W-1:0] PAUSE_ID   = 6'b000111;
    localparam logic [PAUSE_W-1:0] PAUSE_EX   = 6'b001111;
    localparam logic [PAUSE_W-1:0] PAUSE_MEM  = 6'b011111;

    localparam logic [EXC_W-1:0]  EXC_ERET             = 5'h1F;
    localparam logic [ADDR_W-1:0] EXC_ENTRY_ADDR       = 32'hBFC0_0380;
    localparam logic [ADDR_W-1:0] TLB_REFILL_ENTRY_ADDR = 32'hBFC0_0200;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_IF  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_pause_encoder.sv
// Priority encoder: deepest stalling stage selects the pause vector.
module pause_encoder
    import pipeline_ctrl_pkg::*;
(
    input  logic               stall_if,
    input  logic               stall_id,
    input  logic               stall_ex,
    input  logic               stall_mem,
    output logic [PAUSE_W-1:0] pause
);

    always_comb begin
        pause = PAUSE_NONE;
        if (stall_mem)     pause = PAUSE_MEM;
        else if (stall_ex) pause = PAUSE_EX;
        else if (stall_id) pause = PAUSE_ID;
        else if (stall_if) pause = PAUSE_IF;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: merges stage stalls, flushes on exception/ERET,
// holds the redirect until fetch can accept it, counts stall cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] EXC_ENTRY        = EXC_ENTRY_ADDR,
    parameter logic [ADDR_W-1:0] TLB_REFILL_ENTRY = TLB_REFILL_ENTRY_ADDR,
    parameter int unsigned       CNT_W            = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_if,
    input  logic               stall_id,
    input  logic               stall_ex,
    input  logic               stall_mem,
    input  logic               exc_valid,
    input  logic [EXC_W-1:0]   exc_code,
    input  logic               exc_tlb_refill,
    input  logic [ADDR_W-1:0]  cp0_epc,
    output logic [PAUSE_W-1:0] pause,
    output logic               clear,
    output logic               redirect_valid,
    output logic [ADDR_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0]   stall_cycles
);

    state_t             state;
    logic [PAUSE_W-1:0] req_pause;
    logic [ADDR_W-1:0]  target_pc;

    pause_encoder u_pause_encoder (
        .stall_if  (stall_if),
        .stall_id  (stall_id),
        .stall_ex  (stall_ex),
        .stall_mem (stall_mem),
        .pause     (req_pause)
    );

    always_comb begin
        target_pc = EXC_ENTRY;
        if (exc_code == EXC_ERET)  target_pc = cp0_epc;
        else if (exc_tlb_refill)   target_pc = TLB_REFILL_ENTRY;
    end

    // Zero-latency outputs; a flush always overrides any stall request.
    always_comb begin
        pause          = req_pause;
        clear          = 1'b0;
        redirect_valid = 1'b0;
        if (rst) begin
            pause = PAUSE_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        clear = 1'b1;
                        pause = PAUSE_NONE;
                    end
                end
                ST_WAIT_IF: begin
                    pause = req_pause | PAUSE_IF;
                end
                ST_REDIRECT: begin
                    clear          = 1'b1;
                    redirect_valid = 1'b1;
                    pause          = PAUSE_NONE;
                end
                default: pause = req_pause;
            endcase
        end
    end

    // FSM, redirect latch and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            redirect_pc  <= '0;
            stall_cycles <= '0;
        end else begin
            if (pause != PAUSE_NONE) stall_cycles <= stall_cycles + CNT_W'(1);
            case (state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        redirect_pc <= target_pc;
                        state       <= stall_if ? ST_WAIT_IF : ST_REDIRECT;
                    end
                end
                ST_WAIT_IF: begin
                    if (!stall_if) state <= ST_REDIRECT;
                end
                ST_REDIRECT: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl with directed and randomized scenarios.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall_if, stall_id, stall_ex, stall_mem;
    logic        exc_valid, exc_tlb_refill;
    logic [4:0]  exc_code;
    logic [31:0] cp0_epc;
    logic [5:0]  pause;
    logic        clear, redirect_valid;
    logic [31:0] redirect_pc, stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending-redirect bookkeeping in plain booleans.
    bit          m_waiting, m_redirect_next;
    logic [31:0] m_pc, m_cnt;
    logic [5:0]  e_pause;
    logic        e_clear, e_rv;

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .exc_valid      (exc_valid),
        .exc_code       (exc_code),
        .exc_tlb_refill (exc_tlb_refill),
        .cp0_epc        (cp0_epc),
        .pause          (pause),
        .clear          (clear),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_cycles   (stall_cycles)
    );

    // Deepest requesting stage d (IF=1..MEM=4) freezes stages 0..d.
    function automatic logic [5:0] req_vec(input logic sif, sid, sex, smem);
        int d;
        d = smem ? 4 : sex ? 3 : sid ? 2 : sif ? 1 : 0;
        return (d == 0) ? 6'd0 : 6'((1 << (d + 1)) - 1);
    endfunction

    // Apply inputs after a posedge, derive expectations, wait for the negedge.
    task automatic drive(input logic r, sif, sid, sex, smem, ev,
                         input logic [4:0] code, input logic tlb, input logic [31:0] epc);
        rst = r; stall_if = sif; stall_id = sid; stall_ex = sex; stall_mem = smem;
        exc_valid = ev; exc_code = code; exc_tlb_refill = tlb; cp0_epc = epc;
        e_pause = 6'd0; e_clear = 1'b0; e_rv = 1'b0;
        if (!r) begin
            if (m_redirect_next) begin
                e_clear = 1'b1; e_rv = 1'b1;
            end else if (m_waiting) begin
                e_pause = req_vec(sif, sid, sex, smem) | 6'b000011;
            end else if (ev) begin
                e_clear = 1'b1;
            end else begin
                e_pause = req_vec(sif, sid, sex, smem);
            end
        end
        @(negedge clk);
    endtask

    // Advance one clock and update the model from the applied inputs.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_waiting = 0; m_redirect_next = 0; m_pc = 32'd0; m_cnt = 32'd0;
        end else begin
            if (e_pause != 6'd0) m_cnt = m_cnt + 32'd1;
            if (m_redirect_next) begin
                m_redirect_next = 0;
            end else if (m_waiting) begin
                if (!stall_if) begin m_waiting = 0; m_redirect_next = 1; end
            end else if (exc_valid) begin
                m_pc = (exc_code == 5'h1F) ? cp0_epc :
                       exc_tlb_refill ? 32'hBFC0_0200 : 32'hBFC0_0380;
                if (stall_if) m_waiting = 1; else m_redirect_next = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 1, 1, 1, 0, 5'h0, 0, 32'h0);
            vectors++;
            if ({pause, clear, redirect_valid, stall_cycles} !== {6'd0, 1'b0, 1'b0, 32'd0}) begin
                miscompares++;
                $display("FAIL reset cyc%0d: got pause=%b clear=%b rv=%b cnt=%0d want 0/0/0/0",
                         i, pause, clear, redirect_valid, stall_cycles);
            end
            tick();
        end
    endtask

    task automatic test_stall_ex();
        for (int i = 0; i < 34; i++) begin
            drive(0, 0, 1, 1, 0, 0, 5'h0, 0, 32'h0);
            vectors++;
            if ({pause, clear, redirect_valid} !== {6'b001111, e_clear, e_rv} || pause !== e_pause) begin
                miscompares++;
                $display("FAIL stall_ex cyc%0d: got pause=%b clear=%b rv=%b want pause=%b clear=%b rv=%b",
                         i, pause, clear, redirect_valid, e_pause, e_clear, e_rv);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if (stall_cycles !== 32'd34 || pause !== 6'd0) begin
            miscompares++;
            $display("FAIL stall_ex_count: got cnt=%0d pause=%b want cnt=34 pause=000000", stall_cycles, pause);
        end
        tick();
    endtask

    task automatic test_exc_flush();
        drive(0, 0, 0, 0, 0, 1, 5'h04, 0, 32'h0);
        vectors++;
        if ({pause, clear, redirect_valid} !== {6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL exc_flush: got pause=%b clear=%b rv=%b want 000000/1/0", pause, clear, redirect_valid);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if ({redirect_valid, clear, redirect_pc} !== {1'b1, 1'b1, 32'hBFC0_0380}) begin
            miscompares++;
            $display("FAIL exc_redirect: got rv=%b clear=%b pc=%h want 1/1/bfc00380", redirect_valid, clear, redirect_pc);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if ({redirect_valid, clear} !== 2'b00) begin
            miscompares++;
            $display("FAIL exc_idle: got rv=%b clear=%b want 0/0", redirect_valid, clear);
        end
        tick();
    endtask

    task automatic test_eret_wait();
        drive(0, 1, 0, 0, 0, 1, 5'h1F, 0, 32'h8000_1234);
        vectors++;
        if ({pause, clear, redirect_valid} !== {6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL eret_flush: got pause=%b clear=%b rv=%b want 000000/1/0", pause, clear, redirect_valid);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, (i < 5), 0, 0, 0, 0, 5'h0, 0, 32'h0);
            vectors++;
            if ({pause, clear, redirect_valid} !== {6'b000011, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL eret_wait cyc%0d: got pause=%b clear=%b rv=%b want 000011/0/0",
                         i, pause, clear, redirect_valid);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if ({redirect_valid, clear, redirect_pc} !== {1'b1, 1'b1, 32'h8000_1234}) begin
            miscompares++;
            $display("FAIL eret_redirect: got rv=%b clear=%b pc=%h want 1/1/80001234", redirect_valid, clear, redirect_pc);
        end
        tick();
    endtask

    task automatic test_tlb_mem();
        drive(0, 0, 0, 0, 1, 1, 5'h02, 1, 32'h0);
        vectors++;
        if ({pause, clear, redirect_valid} !== {6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL tlb_mem_flush: got pause=%b clear=%b rv=%b want 000000/1/0", pause, clear, redirect_valid);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'hBFC0_0200}) begin
            miscompares++;
            $display("FAIL tlb_redirect: got rv=%b pc=%h want 1/bfc00200", redirect_valid, redirect_pc);
        end
        tick();
    endtask

    task automatic test_reset_wait();
        drive(0, 1, 0, 0, 0, 1, 5'h04, 0, 32'h0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
        vectors++;
        if ({pause, clear, redirect_valid} !== {6'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_wait_in: got pause=%b clear=%b rv=%b want 000000/0/0", pause, clear, redirect_valid);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 5'h0, 0, 32'h0);
            vectors++;
            if ({redirect_valid, clear, pause, stall_cycles} !== {1'b0, 1'b0, 6'd0, 32'd0}) begin
                miscompares++;
                $display("FAIL reset_wait_after cyc%0d: got rv=%b clear=%b pause=%b cnt=%0d want 0/0/000000/0",
                         i, redirect_valid, clear, pause, stall_cycles);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic r, ev;
        logic [4:0] code;
        for (int i = 0; i < 600; i++) begin
            r    = ($urandom_range(0, 59) == 0);
            ev   = !m_waiting && !m_redirect_next && ($urandom_range(0, 7) == 0);
            code = ($urandom_range(0, 2) == 0) ? 5'h1F : 5'($urandom_range(0, 30));
            drive(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0), ev,
                  code, 1'($urandom_range(0, 1)), $urandom());
            vectors++;
            if ({pause, clear, redirect_valid, redirect_pc, stall_cycles} !==
                {e_pause, e_clear, e_rv, m_pc, m_cnt}) begin
                miscompares++;
                $display("FAIL random cyc%0d: got pause=%b clear=%b rv=%b pc=%h cnt=%0d want pause=%b clear=%b rv=%b pc=%h cnt=%0d",
                         i, pause, clear, redirect_valid, redirect_pc, stall_cycles,
                         e_pause, e_clear, e_rv, m_pc, m_cnt);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; stall_if = 0; stall_id = 0; stall_ex = 0; stall_mem = 0;
        exc_valid = 0; exc_code = 5'h0; exc_tlb_refill = 0; cp0_epc = 32'h0;
        m_waiting = 0; m_redirect_next = 0; m_pc = 32'd0; m_cnt = 32'd0;
        e_pause = 6'd0; e_clear = 0; e_rv = 0;
        @(posedge clk); #1;
        test_reset();
        test_stall_ex();
        test_exc_flush();
        test_eret_wait();
        test_tlb_mem();
        test_reset_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
